// File: rtl/jk_reg_bank.sv
// Bank of WIDTH flip-flops with runtime-selectable JK/D/T/SR behaviour, per-bit
// enable, parallel load, sticky illegal-SR flag and a saturating change counter.
module jk_reg_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic             chg,
    output logic             err,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_D  = 2'b01;
    localparam logic [1:0] MODE_T  = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] illegal;
    logic             chg_reg;
    logic             err_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             err_set;
    logic             changed;

    function automatic logic bit_next(input logic qb, input logic enb,
                                      input logic jb, input logic kb,
                                      input logic [1:0] m);
        logic nb;
        nb = qb;
        if (enb) begin
            case (m)
                MODE_JK: nb = (jb & kb) ? ~qb : (jb ? 1'b1 : (kb ? 1'b0 : qb));
                MODE_D:  nb = jb;
                MODE_T:  nb = jb ? ~qb : qb;
                MODE_SR: nb = (jb & ~kb) ? 1'b1 : ((~jb & kb) ? 1'b0 : qb);
                default: nb = qb;
            endcase
        end
        return nb;
    endfunction

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign q_next[gi]  = load ? load_val[gi]
                                      : bit_next(q_reg[gi], en[gi], j[gi], k[gi], mode);
            assign illegal[gi] = en[gi] & j[gi] & k[gi];
        end
    endgenerate

    // A load masks the SR illegal condition since no mode update happens.
    assign err_set = !load && (mode == MODE_SR) && (|illegal);
    assign changed = (q_next != q_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg   <= '0;
            chg_reg <= 1'b0;
            err_reg <= 1'b0;
            cnt_reg <= '0;
        end else begin
            q_reg   <= q_next;
            chg_reg <= changed;
            if (err_set)
                err_reg <= 1'b1;
            else if (err_clr)
                err_reg <= 1'b0;
            if (changed && (cnt_reg != {CNT_W{1'b1}}))
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign q       = q_reg;
    assign chg     = chg_reg;
    assign err     = err_reg;
    assign chg_cnt = cnt_reg;

endmodule
